// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; master is the requesters plus memory model.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_resp_valid;
  logic [31:0] if_rdata;

  logic        ls_req_valid;
  logic        ls_req_ready;
  logic [31:0] ls_addr;
  logic        ls_wen;
  logic [2:0]  ls_memop;
  logic [31:0] ls_wdata;
  logic        ls_resp_valid;
  logic [31:0] ls_rdata;

  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_wen, ls_memop, ls_wdata,
    input  mem_rdata,
    output if_req_ready, if_resp_valid, if_rdata,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_addr, mem_rd, mem_wr, mem_op, mem_wdata
  );

  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_wen, ls_memop, ls_wdata,
    output mem_rdata,
    input  if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_op, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer sharing one memory port
// between the instruction fetch unit and the load/store unit.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [3:0] LatCnt = 4'(LATENCY);
  localparam logic [2:0] OpWord = 3'b010;

  state_e      state_q;
  logic        prio_if_q;   // 1: IFU wins a tie, 0: LSU wins a tie
  logic        owner_ls_q;
  logic        owner_wr_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem_addr_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [2:0]  mem_op_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] ls_rdata_q;
  logic        if_resp_q;
  logic        ls_resp_q;

  logic grant_if;
  logic grant_ls;
  logic capture;

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == StIdle) begin
      grant_if = bus.if_req_valid && (!bus.ls_req_valid || prio_if_q);
      grant_ls = bus.ls_req_valid && (!bus.if_req_valid || !prio_if_q);
    end
  end

  // The counter starts at fire, so it reaches 1 exactly LATENCY cycles after the
  // fire cycle; that is the cycle whose mem_rdata belongs to this command.
  assign capture = ((state_q == StIssue) || (state_q == StWait)) && (cnt_q == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prio_if_q   <= 1'b0;
      owner_ls_q  <= 1'b0;
      owner_wr_q  <= 1'b0;
      cnt_q       <= 4'd0;
      mem_addr_q  <= 32'h0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_op_q    <= 3'b000;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      ls_rdata_q  <= 32'h0;
      if_resp_q   <= 1'b0;
      ls_resp_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_ls) begin
            mem_addr_q  <= bus.ls_addr;
            mem_op_q    <= bus.ls_memop;
            mem_wdata_q <= bus.ls_wdata;
            mem_rd_q    <= !bus.ls_wen;
            mem_wr_q    <= bus.ls_wen;
            owner_ls_q  <= 1'b1;
            owner_wr_q  <= bus.ls_wen;
            prio_if_q   <= 1'b1;
            cnt_q       <= LatCnt;
            state_q     <= StIssue;
          end else if (grant_if) begin
            mem_addr_q  <= bus.if_addr;
            mem_op_q    <= OpWord;
            mem_wdata_q <= 32'h0;
            mem_rd_q    <= 1'b1;
            mem_wr_q    <= 1'b0;
            owner_ls_q  <= 1'b0;
            owner_wr_q  <= 1'b0;
            prio_if_q   <= 1'b0;
            cnt_q       <= LatCnt;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          cnt_q    <= cnt_q - 4'd1;
          state_q  <= StWait;
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            if_resp_q <= !owner_ls_q;
            ls_resp_q <= owner_ls_q;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if_resp_q <= 1'b0;
          ls_resp_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Stores complete without touching ls_rdata.
      if (capture) begin
        if (!owner_ls_q) begin
          if_rdata_q <= bus.mem_rdata;
        end else if (!owner_wr_q) begin
          ls_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_req_ready  = grant_if;
  assign bus.ls_req_ready  = grant_ls;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.mem_wr        = mem_wr_q;
  assign bus.mem_op        = mem_op_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_rdata      = ls_rdata_q;
  assign bus.if_resp_valid = if_resp_q;
  assign bus.ls_resp_valid = ls_resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter at LATENCY=1 and LATENCY=3.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arbiter_if bus1 ();
  mem_arbiter_if bus3 ();

  mem_arbiter #(.LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_arbiter #(.LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        lw;
    logic [2:0]  lop;
    logic [31:0] lwd;
    logic [31:0] mrd;
    logic        xir;
    logic        xlr;
    logic        xrd;
    logic        xwr;
    logic [31:0] xaddr;
    logic [2:0]  xop;
    logic [31:0] xwd;
    logic        xiresp;
    logic [31:0] xird;
    logic        xlresp;
    logic [31:0] xlrd;
  } vec_t;

  localparam int NumVec = 20;
  vec_t vecs [NumVec];

  int n_checks = 0;
  int n_err    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus1.if_req_valid = 1'b0; bus1.if_addr = 32'h0;
    bus1.ls_req_valid = 1'b0; bus1.ls_addr = 32'h0; bus1.ls_wen = 1'b0;
    bus1.ls_memop = 3'b000; bus1.ls_wdata = 32'h0; bus1.mem_rdata = 32'h0;
    bus3.if_req_valid = 1'b0; bus3.if_addr = 32'h0;
    bus3.ls_req_valid = 1'b0; bus3.ls_addr = 32'h0; bus3.ls_wen = 1'b0;
    bus3.ls_memop = 3'b000; bus3.ls_wdata = 32'h0; bus3.mem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic drive1(input vec_t v);
    bus1.if_req_valid = v.iv;  bus1.if_addr  = v.ia;
    bus1.ls_req_valid = v.lv;  bus1.ls_addr  = v.la;
    bus1.ls_wen       = v.lw;  bus1.ls_memop = v.lop;
    bus1.ls_wdata     = v.lwd; bus1.mem_rdata = v.mrd;
  endtask

  task automatic check1(input int i, input vec_t v);
    chk($sformatf("v%0d if_req_ready", i), bus1.if_req_ready, v.xir);
    chk($sformatf("v%0d ls_req_ready", i), bus1.ls_req_ready, v.xlr);
    chk($sformatf("v%0d mem_rd", i), bus1.mem_rd, v.xrd);
    chk($sformatf("v%0d mem_wr", i), bus1.mem_wr, v.xwr);
    chk($sformatf("v%0d mem_addr", i), bus1.mem_addr, v.xaddr);
    chk($sformatf("v%0d mem_op", i), bus1.mem_op, v.xop);
    chk($sformatf("v%0d mem_wdata", i), bus1.mem_wdata, v.xwd);
    chk($sformatf("v%0d if_resp_valid", i), bus1.if_resp_valid, v.xiresp);
    chk($sformatf("v%0d if_rdata", i), bus1.if_rdata, v.xird);
    chk($sformatf("v%0d ls_resp_valid", i), bus1.ls_resp_valid, v.xlresp);
    chk($sformatf("v%0d ls_rdata", i), bus1.ls_rdata, v.xlrd);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_addr"}, bus1.mem_addr, 32'h0);
    chk({tag, " mem_rd"}, bus1.mem_rd, 32'h0);
    chk({tag, " mem_wr"}, bus1.mem_wr, 32'h0);
    chk({tag, " mem_op"}, bus1.mem_op, 32'h0);
    chk({tag, " mem_wdata"}, bus1.mem_wdata, 32'h0);
    chk({tag, " if_rdata"}, bus1.if_rdata, 32'h0);
    chk({tag, " ls_rdata"}, bus1.ls_rdata, 32'h0);
    chk({tag, " if_resp_valid"}, bus1.if_resp_valid, 32'h0);
    chk({tag, " ls_resp_valid"}, bus1.ls_resp_valid, 32'h0);
  endtask

  initial begin
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] al;
    logic [31:0] ad;
    int          ng;
    int          gcyc [4];
    a0 = 32'h8000_0000;
    a1 = 32'h8000_0004;
    al = 32'h8000_1004;
    ad = 32'h8000_2000;

    // iv ia lv la lw lop lwd mrd | ir lr rd wr addr op wd iresp ird lresp lrd
    vecs[0]  = '{1'b1, a0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0000_0413,
                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, a0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0000_0413,
                 1'b0, 1'b0, 1'b1, 1'b0, a0, 3'd2, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, a0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, a0, 3'd2, 32'h0, 1'b0, 32'h413, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, a0, 1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, a0, 3'd2, 32'h0, 1'b1, 32'h413, 1'b0, 32'h0};
    // Contention: prio points at LSU, store wins; IFU keeps requesting.
    vecs[4]  = '{1'b1, a1, 1'b1, al, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b0, a0, 3'd2, 32'h0, 1'b0, 32'h413, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, a1, 1'b0, al, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'h5555_5555,
                 1'b0, 1'b0, 1'b0, 1'b1, al, 3'd0, 32'hDEAD_BEEF, 1'b0, 32'h413, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, a1, 1'b0, al, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'h5555_5555,
                 1'b0, 1'b0, 1'b0, 1'b0, al, 3'd0, 32'hDEAD_BEEF, 1'b0, 32'h413, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, a1, 1'b0, al, 1'b1, 3'd0, 32'hDEAD_BEEF, 32'h5555_5555,
                 1'b0, 1'b0, 1'b0, 1'b0, al, 3'd0, 32'hDEAD_BEEF, 1'b0, 32'h413, 1'b1, 32'h0};
    // IFU wins the next tie; LSU load waits with stable payload.
    vecs[8]  = '{1'b1, a1, 1'b1, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0010_0093,
                 1'b1, 1'b0, 1'b0, 1'b0, al, 3'd0, 32'hDEAD_BEEF, 1'b0, 32'h413, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, a1, 1'b1, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0010_0093,
                 1'b0, 1'b0, 1'b1, 1'b0, a1, 3'd2, 32'h0, 1'b0, 32'h413, 1'b0, 32'h0};
    vecs[10] = '{1'b0, a1, 1'b1, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, a1, 3'd2, 32'h0, 1'b0, 32'h0010_0093, 1'b0, 32'h0};
    vecs[11] = '{1'b0, a1, 1'b1, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, a1, 3'd2, 32'h0, 1'b1, 32'h0010_0093, 1'b0, 32'h0};
    vecs[12] = '{1'b0, a1, 1'b1, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b0, a1, 3'd2, 32'h0, 1'b0, 32'h0010_0093, 1'b0, 32'h0};
    vecs[13] = '{1'b0, a1, 1'b0, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0000_00AB,
                 1'b0, 1'b0, 1'b1, 1'b0, ad, 3'd4, 32'h1234_5678, 1'b0, 32'h0010_0093, 1'b0,
                 32'h0};
    vecs[14] = '{1'b0, a1, 1'b0, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, ad, 3'd4, 32'h1234_5678, 1'b0, 32'h0010_0093, 1'b0,
                 32'hAB};
    vecs[15] = '{1'b0, a1, 1'b0, ad, 1'b0, 3'd4, 32'h1234_5678, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, ad, 3'd4, 32'h1234_5678, 1'b0, 32'h0010_0093, 1'b1,
                 32'hAB};
    // Store after a load: ls_rdata must keep the load value.
    vecs[16] = '{1'b0, a1, 1'b1, ad, 1'b1, 3'd2, 32'h0F0F_0F0F, 32'h7777_7777,
                 1'b0, 1'b1, 1'b0, 1'b0, ad, 3'd4, 32'h1234_5678, 1'b0, 32'h0010_0093, 1'b0,
                 32'hAB};
    vecs[17] = '{1'b0, a1, 1'b0, ad, 1'b1, 3'd2, 32'h0F0F_0F0F, 32'h7777_7777,
                 1'b0, 1'b0, 1'b0, 1'b1, ad, 3'd2, 32'h0F0F_0F0F, 1'b0, 32'h0010_0093, 1'b0,
                 32'hAB};
    vecs[18] = '{1'b0, a1, 1'b0, ad, 1'b1, 3'd2, 32'h0F0F_0F0F, 32'h7777_7777,
                 1'b0, 1'b0, 1'b0, 1'b0, ad, 3'd2, 32'h0F0F_0F0F, 1'b0, 32'h0010_0093, 1'b0,
                 32'hAB};
    vecs[19] = '{1'b0, a1, 1'b0, ad, 1'b1, 3'd2, 32'h0F0F_0F0F, 32'h7777_7777,
                 1'b0, 1'b0, 1'b0, 1'b0, ad, 3'd2, 32'h0F0F_0F0F, 1'b0, 32'h0010_0093, 1'b1,
                 32'hAB};

    // Reset state, including the combinational ready while held in reset.
    idle_inputs();
    rst_n = 1'b0;
    #4;
    check_all_zero("reset");
    chk("reset ls_req_ready idle", bus1.ls_req_ready, 32'h0);
    bus1.if_req_valid = 1'b1;
    #1;
    chk("reset if_req_ready follows valid", bus1.if_req_ready, 32'h1);
    do_reset();

    for (int i = 0; i < NumVec; i++) begin
      drive1(vecs[i]);
      #4;
      check1(i, vecs[i]);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // LATENCY=3: only the word driven in c0+3 may be captured.
    bus3.ls_req_valid = 1'b1; bus3.ls_addr = 32'h8000_3000; bus3.ls_wen = 1'b0;
    bus3.ls_memop = 3'b001; bus3.mem_rdata = 32'h1111_1111;
    #4;
    chk("lat3 c0 ls_req_ready", bus3.ls_req_ready, 32'h1);
    next_cycle();
    bus3.ls_req_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      bus3.mem_rdata = (i == 3) ? 32'hCAFE_F00D : 32'h1111_1111;
      #4;
      chk($sformatf("lat3 c%0d ls_resp_valid", i), bus3.ls_resp_valid, (i == 5));
      chk($sformatf("lat3 c%0d mem_rd", i), bus3.mem_rd, (i == 1));
      if (i >= 5) chk($sformatf("lat3 c%0d ls_rdata", i), bus3.ls_rdata, 32'hCAFE_F00D);
      next_cycle();
    end

    // Reset during WAIT drops the transaction.
    bus1.if_req_valid = 1'b1; bus1.if_addr = a0; bus1.mem_rdata = 32'h1357_9BDF;
    #4;
    chk("rst_mid c0 if_req_ready", bus1.if_req_ready, 32'h1);
    next_cycle();
    bus1.if_req_valid = 1'b0;
    #4;
    chk("rst_mid c1 mem_rd", bus1.mem_rd, 32'h1);
    next_cycle();
    rst_n = 1'b0;
    #4;
    check_all_zero("rst_mid during reset");
    chk("rst_mid during reset if_req_ready", bus1.if_req_ready, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #4;
      chk($sformatf("rst_mid after %0d quiet", i),
          {bus1.if_resp_valid, bus1.ls_resp_valid, bus1.mem_rd, bus1.mem_wr}, 32'h0);
      next_cycle();
    end
    bus1.if_req_valid = 1'b1; bus1.if_addr = a1; bus1.mem_rdata = 32'hA5A5_A5A5;
    #4;
    chk("rst_mid read c0 if_req_ready", bus1.if_req_ready, 32'h1);
    next_cycle();
    bus1.if_req_valid = 1'b0;
    #4;
    chk("rst_mid read c1 mem_rd", bus1.mem_rd, 32'h1);
    chk("rst_mid read c1 mem_addr", bus1.mem_addr, a1);
    next_cycle();
    #4;
    chk("rst_mid read c2 if_resp_valid", bus1.if_resp_valid, 32'h0);
    next_cycle();
    #4;
    chk("rst_mid read c3 if_resp_valid", bus1.if_resp_valid, 32'h1);
    chk("rst_mid read c3 if_rdata", bus1.if_rdata, 32'hA5A5_A5A5);
    next_cycle();

    // Round-robin with both requesters held valid from reset.
    do_reset();
    bus1.if_req_valid = 1'b1; bus1.if_addr = a0;
    bus1.ls_req_valid = 1'b1; bus1.ls_addr = ad; bus1.ls_wen = 1'b0; bus1.ls_memop = 3'b010;
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      #4;
      if (bus1.if_req_ready || bus1.ls_req_ready) begin
        gcyc[ng] = cyc;
        chk($sformatf("rr grant%0d ls_req_ready", ng), bus1.ls_req_ready, (ng % 2 == 0));
        chk($sformatf("rr grant%0d if_req_ready", ng), bus1.if_req_ready, (ng % 2 == 1));
        chk($sformatf("rr grant%0d cycle", ng), gcyc[ng], 4 * ng);
        ng++;
      end
      next_cycle();
    end
    chk("rr grant count", ng, 4);
    idle_inputs();
    repeat (5) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared data-memory port of the NPC core. It lets the instruction fetch unit (IFU) and the load/store unit (LSU) share one memory access port, with round-robin arbitration and a fixed, parameterised memory latency. It drives the same command fields as the data memory: address, read strobe, write strobe, 3-bit MemOp and write data. It returns each response to the requester that issued it. It sits between the IFU/LSU and the DPI-C backed memory model.

## Interface
- LATENCY, 1, cycles from the command-issue cycle to valid mem_rdata; legal range 1..15.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  IFU read request.
- if_req_ready  out  1  IFU request accepted this cycle.
- if_addr  in  32  IFU fetch address.
- if_resp_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  32  fetched word.
- ls_req_valid  in  1  LSU request.
- ls_req_ready  out  1  LSU request accepted this cycle.
- ls_addr  in  32  LSU byte address.
- ls_wen  in  1  1 = write (store), 0 = read (load).
- ls_memop  in  3  MemOp encoding: 000/001/010 = byte/half/word, sign-extended on read; 100/101 = byte/half, zero-extended.
- ls_wdata  in  32  store data.
- ls_resp_valid  out  1  one-cycle pulse; load data is valid, or the store is complete.
- ls_rdata  out  32  load data.
- mem_addr  out  32  memory address.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_op  out  3  MemOp sent to memory.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- A fire is `valid && ready` on a port.
- **Ready.** req_ready is high only in IDLE, and only for the arbitration winner. Ready depends combinationally on the valids.
- **Arbitration.**
  - If only one port is valid, that port wins.
  - If both are valid, the port named by the prio bit wins.
  - After every grant, prio points to the other port.
  - prio resets to LSU.
- **Fire (IDLE).** The command is latched into the mem_* output registers and the owner is recorded. The state moves to ISSUE.
  - IFU command: mem_op=010, mem_wdata=0, read.
  - LSU command: ls_addr/ls_memop/ls_wdata are passed through unmodified; ls_wen selects mem_wr or mem_rd.
- **ISSUE.** Exactly one of mem_rd/mem_wr is high for this single cycle. A counter is loaded with LATENCY. Next state is WAIT.
- **WAIT.** The counter decrements every cycle.
  - On the cycle where the counter equals 1, mem_rdata is captured into the owner's rdata register. Store responses leave ls_rdata unchanged.
  - Next state is RESP.
- **RESP.** The owner's resp_valid is high for one cycle. There is no back-pressure: requesters must accept the response. Next state is IDLE.
- **Held values.**
  - mem_addr/mem_op/mem_wdata hold their value through WAIT and RESP; mem_rd/mem_wr are 0 outside ISSUE.
  - if_rdata/ls_rdata hold until the next capture for that port.
- **Not checked.** The arbiter does not check ls_memop legality, address alignment, or writes with an unsigned MemOp. The memory model defines their behaviour.
- **Requester rule.** A requester keeps valid and its payload stable until it sees ready. The arbiter only samples the payload on fire.

## Timing
- **Reset values** (rst_n low, applied immediately and asynchronously):
  - state=IDLE, prio=LSU, counter=0.
  - mem_addr, mem_rd, mem_wr, mem_op, mem_wdata, if_rdata, ls_rdata, if_resp_valid, ls_resp_valid are all 0.
  - req_ready follows the combinational rule from IDLE.
- **Latency.** Fire in cycle c0 gives:
  - ISSUE strobe in c0+1;
  - mem_rdata sampled at the end of c0+LATENCY;
  - resp_valid in c0+LATENCY+2;
  - IDLE in c0+LATENCY+3, where the earliest next fire can occur.
- **Throughput.** One transaction per LATENCY+3 cycles.
- **Simultaneous events.**
  - Both valid in IDLE: exactly one ready is high. The loser's valid persists, and it wins at the next IDLE if it is still valid.
  - A requester's valid arriving during ISSUE/WAIT/RESP is ignored until IDLE.
- **Reset mid-transaction.** The transaction is dropped: no strobe and no resp_valid are emitted after rst_n deasserts.

## Test plan
- **IFU read, LATENCY=1.** if_addr=0x80000000 valid in c0; memory returns 0x00000413. Expect:
  - if_req_ready=1 in c0;
  - mem_rd=1, mem_addr=0x80000000, mem_op=010 in c1 only;
  - if_resp_valid=1 with if_rdata=0x00000413 in c3.
- **Contention after reset.** Both valid in c0: LSU store ls_addr=0x80001004, ls_memop=000, ls_wdata=0xDEADBEEF; IFU read. Expect:
  - ls_req_ready=1 and if_req_ready=0 in c0;
  - mem_wr=1 in c1 only, with mem_wdata=0xDEADBEEF and mem_op=000;
  - ls_resp_valid in c3;
  - IFU fires in c4.
- **Round-robin.** Both requesters held valid continuously for 4 grants → grant order LSU, IFU, LSU, IFU. No ready is asserted outside IDLE.
- **LATENCY=3 sampling.** The memory drives 0x11111111 on every cycle except c0+3, where it drives 0xCAFEF00D. LSU load fires in c0 → ls_resp_valid in c0+5 with ls_rdata=0xCAFEF00D.
- **Reset mid-operation.** rst_n pulsed low during WAIT. Expect:
  - all outputs read 0 during reset;
  - no resp_valid after release;
  - a subsequent IFU read completes normally.
- **Data hold.** After an IFU response, an LSU store completes. Expect if_rdata unchanged, and ls_rdata unchanged by the store.
